// File: rtl/mouse_position_tracker_if.sv
// Bus between the PS/2 master state machine, the position tracker and the processor-side consumer.
// The slave modport is the tracker's view; the master modport is its environment's.
interface mouse_position_tracker_if #(
   parameter int unsigned POS_WIDTH = 10
);
   logic                 PKT_VALID;
   logic [7:0]           STATUS_RAW;
   logic [7:0]           DX_RAW;
   logic [7:0]           DY_RAW;
   logic [7:0]           DZ_RAW;
   logic                 RECENTRE;
   logic                 UPD_ACK;
   logic [POS_WIDTH-1:0] POS_X;
   logic [POS_WIDTH-1:0] POS_Y;
   logic [POS_WIDTH-1:0] POS_Z;
   logic [2:0]           BUTTONS;
   logic [2:0]           CLICK_EVT;
   logic                 UPD_VALID;
   logic [7:0]           OVERRUN_CNT;

   modport master (
      output PKT_VALID, STATUS_RAW, DX_RAW, DY_RAW, DZ_RAW, RECENTRE, UPD_ACK,
      input  POS_X, POS_Y, POS_Z, BUTTONS, CLICK_EVT, UPD_VALID, OVERRUN_CNT
   );

   modport slave (
      input  PKT_VALID, STATUS_RAW, DX_RAW, DY_RAW, DZ_RAW, RECENTRE, UPD_ACK,
      output POS_X, POS_Y, POS_Z, BUTTONS, CLICK_EVT, UPD_VALID, OVERRUN_CNT
   );
endinterface

// File: rtl/mouse_position_tracker.sv
// Two-stage PS/2 packet to cursor-position tracker: stage 1 builds scaled signed deltas,
// stage 2 commits them per axis (saturate or wrap), with click edges and an ack/overrun handshake.
module mouse_position_tracker #(
   parameter int unsigned POS_WIDTH  = 10,
   parameter int          LIMIT_X    = 160,
   parameter int          LIMIT_Y    = 120,
   parameter int          LIMIT_Z    = 256,
   parameter bit          WRAP_X     = 1'b0,
   parameter bit          WRAP_Y     = 1'b0,
   parameter bit          WRAP_Z     = 1'b1,
   parameter int          SENS_SHIFT = 0,
   parameter bit          INVERT_Y   = 1'b0
) (
   input logic                    CLK,
   input logic                    RESET,
   mouse_position_tracker_if.slave bus
);

   localparam int DW = POS_WIDTH + 2;
   typedef logic signed [DW-1:0] delta_t;

   localparam logic [POS_WIDTH-1:0] CENTRE_X = POS_WIDTH'(LIMIT_X / 2);
   localparam logic [POS_WIDTH-1:0] CENTRE_Y = POS_WIDTH'(LIMIT_Y / 2);
   localparam logic [POS_WIDTH-1:0] CENTRE_Z = POS_WIDTH'(LIMIT_Z / 2);

   // 9-bit PS/2 delta; an overflowed axis is pinned to the extreme of its sign
   function automatic delta_t build_xy(input logic ovf, input logic sign, input logic [7:0] raw);
      logic [8:0] v;
      if (ovf) begin
         v = sign ? 9'b1_0000_0000 : 9'b0_1111_1111;
      end else begin
         v = {sign, raw};
      end
      return {{(DW-9){v[8]}}, v};
   endfunction

   function automatic delta_t clamp_wrap(input delta_t d, input int limit);
      delta_t lim;
      lim = delta_t'(limit - 1);
      if (d > lim) begin
         return lim;
      end else if (d < -lim) begin
         return -lim;
      end else begin
         return d;
      end
   endfunction

   function automatic logic [POS_WIDTH-1:0] axis_next(input logic [POS_WIDTH-1:0] pos,
                                                      input delta_t d, input int limit,
                                                      input bit wrap);
      delta_t s;
      delta_t lim;
      delta_t r;
      lim = delta_t'(limit);
      s   = $signed({2'b00, pos}) + d;
      if (s[DW-1]) begin
         r = wrap ? (s + lim) : delta_t'(0);
      end else if (s >= lim) begin
         r = wrap ? (s - lim) : (lim - delta_t'(1));
      end else begin
         r = s;
      end
      return r[POS_WIDTH-1:0];
   endfunction

   delta_t w_dx;
   delta_t w_dy;
   delta_t w_dz;
   logic   w_commit;
   logic   w_unused;

   delta_t               r_dx;
   delta_t               r_dy;
   delta_t               r_dz;
   logic [2:0]           r_btn_s1;
   logic                 r_s1_valid;
   logic [POS_WIDTH-1:0] r_pos_x;
   logic [POS_WIDTH-1:0] r_pos_y;
   logic [POS_WIDTH-1:0] r_pos_z;
   logic [2:0]           r_buttons;
   logic [2:0]           r_click;
   logic                 r_upd_valid;
   logic [7:0]           r_overrun;

   assign w_unused = ^{bus.STATUS_RAW[3], 1'b0};

   always_comb begin
      w_dx = build_xy(bus.STATUS_RAW[6], bus.STATUS_RAW[4], bus.DX_RAW) >>> SENS_SHIFT;
      w_dy = build_xy(bus.STATUS_RAW[7], bus.STATUS_RAW[5], bus.DY_RAW) >>> SENS_SHIFT;
      w_dz = {{(DW-8){bus.DZ_RAW[7]}}, bus.DZ_RAW};
      if (INVERT_Y) begin
         w_dy = -w_dy;
      end else begin
         w_dy = w_dy;
      end
      // A wrap axis must never move more than one full lap per packet
      if (WRAP_X) begin
         w_dx = clamp_wrap(w_dx, LIMIT_X);
      end else begin
         w_dx = w_dx;
      end
      if (WRAP_Y) begin
         w_dy = clamp_wrap(w_dy, LIMIT_Y);
      end else begin
         w_dy = w_dy;
      end
      if (WRAP_Z) begin
         w_dz = clamp_wrap(w_dz, LIMIT_Z);
      end else begin
         w_dz = w_dz;
      end
   end

   // RECENTRE is itself an update for the handshake
   assign w_commit = bus.RECENTRE | r_s1_valid;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_s1_valid  <= 1'b0;
         r_dx        <= '0;
         r_dy        <= '0;
         r_dz        <= '0;
         r_btn_s1    <= 3'b000;
         r_pos_x     <= CENTRE_X;
         r_pos_y     <= CENTRE_Y;
         r_pos_z     <= CENTRE_Z;
         r_buttons   <= 3'b000;
         r_click     <= 3'b000;
         r_upd_valid <= 1'b0;
         r_overrun   <= 8'd0;
      end else begin
         if (bus.RECENTRE) begin
            r_s1_valid <= 1'b0;
            r_pos_x    <= CENTRE_X;
            r_pos_y    <= CENTRE_Y;
            r_pos_z    <= CENTRE_Z;
            r_click    <= 3'b000;
         end else begin
            r_s1_valid <= bus.PKT_VALID;
            if (bus.PKT_VALID) begin
               r_dx     <= w_dx;
               r_dy     <= w_dy;
               r_dz     <= w_dz;
               r_btn_s1 <= bus.STATUS_RAW[2:0];
            end
            if (r_s1_valid) begin
               r_pos_x   <= axis_next(r_pos_x, r_dx, LIMIT_X, WRAP_X);
               r_pos_y   <= axis_next(r_pos_y, r_dy, LIMIT_Y, WRAP_Y);
               r_pos_z   <= axis_next(r_pos_z, r_dz, LIMIT_Z, WRAP_Z);
               r_buttons <= r_btn_s1;
               r_click   <= r_btn_s1 & ~r_buttons;
            end else begin
               r_click   <= 3'b000;
            end
         end

         if (w_commit) begin
            r_upd_valid <= 1'b1;
            if (r_upd_valid && !bus.UPD_ACK && (r_overrun != 8'hFF)) begin
               r_overrun <= r_overrun + 8'd1;
            end
         end else if (bus.UPD_ACK) begin
            r_upd_valid <= 1'b0;
         end
      end
   end

   assign bus.POS_X       = r_pos_x;
   assign bus.POS_Y       = r_pos_y;
   assign bus.POS_Z       = r_pos_z;
   assign bus.BUTTONS     = r_buttons;
   assign bus.CLICK_EVT   = r_click;
   assign bus.UPD_VALID   = r_upd_valid;
   assign bus.OVERRUN_CNT = r_overrun;

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Directed bench: dut_a uses default parameters, dut_b scales by 2, dut_c inverts Y.
module tb_mouse_position_tracker;

   logic CLK = 1'b0;
   logic RESET;
   int   checks = 0;
   int   errors = 0;

   always #5 CLK = ~CLK;

   mouse_position_tracker_if #(.POS_WIDTH(10)) bus_a ();
   mouse_position_tracker_if #(.POS_WIDTH(10)) bus_b ();
   mouse_position_tracker_if #(.POS_WIDTH(10)) bus_c ();

   mouse_position_tracker dut_a (.CLK(CLK), .RESET(RESET), .bus(bus_a));
   mouse_position_tracker #(.SENS_SHIFT(1)) dut_b (.CLK(CLK), .RESET(RESET), .bus(bus_b));
   mouse_position_tracker #(.INVERT_Y(1'b1)) dut_c (.CLK(CLK), .RESET(RESET), .bus(bus_c));

   typedef struct {
      logic [7:0] st;
      logic [7:0] dx;
      logic [7:0] dy;
      logic [7:0] dz;
      int         ex;
      int         ey;
      int         ez;
      int         eb;
      int         ec;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_pkt(input logic v, input logic [7:0] st, input logic [7:0] dx,
                            input logic [7:0] dy, input logic [7:0] dz);
      bus_a.PKT_VALID = v; bus_a.STATUS_RAW = st; bus_a.DX_RAW = dx; bus_a.DY_RAW = dy; bus_a.DZ_RAW = dz;
      bus_b.PKT_VALID = v; bus_b.STATUS_RAW = st; bus_b.DX_RAW = dx; bus_b.DY_RAW = dy; bus_b.DZ_RAW = dz;
      bus_c.PKT_VALID = v; bus_c.STATUS_RAW = st; bus_c.DX_RAW = dx; bus_c.DY_RAW = dy; bus_c.DZ_RAW = dz;
   endtask

   // one packet, returning #1 after its commit edge
   task automatic send(input logic [7:0] st, input logic [7:0] dx, input logic [7:0] dy,
                       input logic [7:0] dz);
      @(negedge CLK);
      drive_pkt(1'b1, st, dx, dy, dz);
      @(negedge CLK);
      drive_pkt(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      @(posedge CLK);
      #1;
   endtask

   task automatic ack_a();
      @(negedge CLK);
      bus_a.UPD_ACK = 1'b1;
      @(negedge CLK);
      bus_a.UPD_ACK = 1'b0;
      chk("upd_valid_after_ack", bus_a.UPD_VALID, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{8'h08, 8'h05, 8'h03, 8'h00,  85,  63, 128, 0, 0};
      vecs[1]  = '{8'h18, 8'h9C, 8'h00, 8'h00,   0,  63, 128, 0, 0};
      vecs[2]  = '{8'h48, 8'h00, 8'h00, 8'h00, 159,  63, 128, 0, 0};
      vecs[3]  = '{8'h08, 8'h00, 8'h00, 8'h7A, 159,  63, 250, 0, 0};
      vecs[4]  = '{8'h08, 8'h00, 8'h00, 8'h0A, 159,  63,   4, 0, 0};
      vecs[5]  = '{8'h08, 8'h00, 8'h00, 8'hF6, 159,  63, 250, 0, 0};
      vecs[6]  = '{8'h28, 8'h00, 8'h00, 8'h00, 159,   0, 250, 0, 0};
      vecs[7]  = '{8'h88, 8'h00, 8'h00, 8'h00, 159, 119, 250, 0, 0};
      vecs[8]  = '{8'hA8, 8'h00, 8'h00, 8'h00, 159,   0, 250, 0, 0};
      vecs[9]  = '{8'h1D, 8'hFF, 8'h00, 8'h00, 158,   0, 250, 5, 5};
      vecs[10] = '{8'h08, 8'h00, 8'h00, 8'h00, 158,   0, 250, 0, 0};

      drive_pkt(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      bus_a.RECENTRE = 1'b0; bus_a.UPD_ACK = 1'b0;
      bus_b.RECENTRE = 1'b0; bus_b.UPD_ACK = 1'b0;
      bus_c.RECENTRE = 1'b0; bus_c.UPD_ACK = 1'b0;
      RESET = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;

      chk("reset_pos_x", bus_a.POS_X, 80);
      chk("reset_pos_y", bus_a.POS_Y, 60);
      chk("reset_pos_z", bus_a.POS_Z, 128);
      chk("reset_buttons", bus_a.BUTTONS, 0);
      chk("reset_click", bus_a.CLICK_EVT, 0);
      chk("reset_upd_valid", bus_a.UPD_VALID, 0);
      chk("reset_overrun", bus_a.OVERRUN_CNT, 0);

      // latency: nothing visible after the first edge
      @(negedge CLK);
      drive_pkt(1'b1, 8'h08, 8'h07, 8'h05, 8'h00);
      @(negedge CLK);
      drive_pkt(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      chk("latency_x_unchanged", bus_a.POS_X, 80);
      chk("latency_upd_low", bus_a.UPD_VALID, 0);
      @(posedge CLK);
      #1;
      chk("a_x_plus7", bus_a.POS_X, 87);
      chk("a_y_plus5", bus_a.POS_Y, 65);
      chk("b_x_shift_pos", bus_b.POS_X, 83);
      chk("b_y_shift_pos", bus_b.POS_Y, 62);
      chk("c_x_noinv", bus_c.POS_X, 87);
      chk("c_y_inverted", bus_c.POS_Y, 55);
      chk("a_upd_set", bus_a.UPD_VALID, 1);

      send(8'h18, 8'hF9, 8'h00, 8'h00);
      chk("a_x_minus7", bus_a.POS_X, 80);
      chk("b_x_shift_neg", bus_b.POS_X, 79);
      chk("c_x_minus7", bus_c.POS_X, 80);
      chk("a_overrun_first", bus_a.OVERRUN_CNT, 1);

      // asynchronous reset takes effect without a clock edge
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      chk("async_rst_overrun", bus_a.OVERRUN_CNT, 0);
      chk("async_rst_upd", bus_a.UPD_VALID, 0);
      chk("async_rst_b_x", bus_b.POS_X, 80);
      chk("async_rst_c_y", bus_c.POS_Y, 60);
      @(negedge CLK);
      RESET = 1'b0;

      for (int i = 0; i < 11; i++) begin
         send(vecs[i].st, vecs[i].dx, vecs[i].dy, vecs[i].dz);
         chk($sformatf("vec%0d_x", i), bus_a.POS_X, vecs[i].ex);
         chk($sformatf("vec%0d_y", i), bus_a.POS_Y, vecs[i].ey);
         chk($sformatf("vec%0d_z", i), bus_a.POS_Z, vecs[i].ez);
         chk($sformatf("vec%0d_btn", i), bus_a.BUTTONS, vecs[i].eb);
         chk($sformatf("vec%0d_click", i), bus_a.CLICK_EVT, vecs[i].ec);
         chk($sformatf("vec%0d_upd", i), bus_a.UPD_VALID, 1);
         ack_a();
      end
      chk("table_overrun", bus_a.OVERRUN_CNT, 0);

      // back-to-back clicks, no ack: second commit overruns
      @(negedge CLK);
      drive_pkt(1'b1, 8'h09, 8'h00, 8'h00, 8'h00);
      @(negedge CLK);
      drive_pkt(1'b1, 8'h0B, 8'h00, 8'h00, 8'h00);
      @(negedge CLK);
      drive_pkt(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      chk("click_left", bus_a.CLICK_EVT, 1);
      chk("click_ovr_before", bus_a.OVERRUN_CNT, 0);
      @(posedge CLK);
      #1;
      chk("click_right", bus_a.CLICK_EVT, 2);
      chk("click_buttons", bus_a.BUTTONS, 3);
      chk("click_overrun", bus_a.OVERRUN_CNT, 1);
      @(posedge CLK);
      #1;
      chk("click_cleared", bus_a.CLICK_EVT, 0);

      // same, with ack coinciding with the second commit
      ack_a();
      send(8'h08, 8'h00, 8'h00, 8'h00);
      ack_a();
      @(negedge CLK);
      drive_pkt(1'b1, 8'h09, 8'h00, 8'h00, 8'h00);
      @(negedge CLK);
      drive_pkt(1'b1, 8'h0B, 8'h00, 8'h00, 8'h00);
      @(negedge CLK);
      drive_pkt(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      bus_a.UPD_ACK = 1'b1;
      chk("ack_click_left", bus_a.CLICK_EVT, 1);
      @(posedge CLK);
      #1;
      chk("ack_click_right", bus_a.CLICK_EVT, 2);
      chk("ack_commit_upd", bus_a.UPD_VALID, 1);
      chk("ack_commit_overrun", bus_a.OVERRUN_CNT, 1);
      @(negedge CLK);
      bus_a.UPD_ACK = 1'b0;

      // RECENTRE while one packet is in flight and another is offered
      ack_a();
      @(negedge CLK);
      drive_pkt(1'b1, 8'h0C, 8'h10, 8'h10, 8'h10);
      @(negedge CLK);
      drive_pkt(1'b1, 8'h0C, 8'h10, 8'h10, 8'h10);
      bus_a.RECENTRE = 1'b1;
      @(negedge CLK);
      drive_pkt(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      bus_a.RECENTRE = 1'b0;
      chk("recentre_x", bus_a.POS_X, 80);
      chk("recentre_y", bus_a.POS_Y, 60);
      chk("recentre_z", bus_a.POS_Z, 128);
      chk("recentre_upd", bus_a.UPD_VALID, 1);
      chk("recentre_buttons", bus_a.BUTTONS, 3);
      chk("recentre_click", bus_a.CLICK_EVT, 0);
      chk("recentre_overrun", bus_a.OVERRUN_CNT, 1);
      repeat (2) @(posedge CLK);
      #1;
      chk("recentre_flush_x", bus_a.POS_X, 80);
      chk("recentre_flush_z", bus_a.POS_Z, 128);
      chk("recentre_flush_btn", bus_a.BUTTONS, 3);

      // reset with a packet sitting in stage 1
      send(8'h08, 8'h10, 8'h00, 8'h00);
      chk("pre_rst_x", bus_a.POS_X, 96);
      chk("pre_rst_overrun", bus_a.OVERRUN_CNT, 2);
      @(negedge CLK);
      drive_pkt(1'b1, 8'h0D, 8'h10, 8'h00, 8'h00);
      @(negedge CLK);
      drive_pkt(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      RESET = 1'b1;
      #1;
      chk("mid_rst_x", bus_a.POS_X, 80);
      chk("mid_rst_upd", bus_a.UPD_VALID, 0);
      chk("mid_rst_overrun", bus_a.OVERRUN_CNT, 0);
      @(negedge CLK);
      RESET = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("post_rst_x", bus_a.POS_X, 80);
      chk("post_rst_btn", bus_a.BUTTONS, 0);
      chk("post_rst_upd", bus_a.UPD_VALID, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mouse_position_tracker.md
Name: mouse_position_tracker

Overview:
- Parametrised successor to the fixed X/Y/Z position pre-processing in the mouse transceiver.
- Takes raw PS/2 packets from the mouse master state machine and produces three cursor axes with per-axis limit and mode (saturate or wrap).
- Adds sensitivity scaling, optional Y inversion, button click-edge events, and a valid/ack update handshake with overrun counting toward the processor bus.
- Sits between the master SM data registers and the bus/display logic.

Parameters:
POS_WIDTH, 10, width of each position output, unsigned; must hold LIMIT-1 for every axis
LIMIT_X, 160, X range 0..LIMIT_X-1
LIMIT_Y, 120, Y range 0..LIMIT_Y-1
LIMIT_Z, 256, Z range 0..LIMIT_Z-1
WRAP_X, 0, 0 = saturate at range ends, 1 = wrap modulo LIMIT_X
WRAP_Y, 0, same as WRAP_X, for Y
WRAP_Z, 1, same as WRAP_X, for Z
SENS_SHIFT, 0, X/Y deltas arithmetic-shifted right by this amount (0..4)
INVERT_Y, 0, 1 = negate Y delta before the add

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
PKT_VALID  in  1  one-cycle strobe; raw packet inputs valid this cycle
STATUS_RAW  in  8  PS/2 status byte: [7] Y ovf, [6] X ovf, [5] Y sign, [4] X sign, [2:0] mid/right/left
DX_RAW  in  8  X delta low byte
DY_RAW  in  8  Y delta low byte
DZ_RAW  in  8  wheel delta, two's complement
RECENTRE  in  1  synchronous request to move all axes to LIMIT/2
UPD_ACK  in  1  consumer acknowledge of UPD_VALID
POS_X  out  POS_WIDTH  X position
POS_Y  out  POS_WIDTH  Y position
POS_Z  out  POS_WIDTH  Z position
BUTTONS  out  3  latched STATUS_RAW[2:0]
CLICK_EVT  out  3  one-cycle pulse per button on its 0->1 edge
UPD_VALID  out  1  a new position is available and not yet acknowledged
OVERRUN_CNT  out  8  updates committed while UPD_VALID=1 and UPD_ACK=0; saturates at 255

Behaviour:
- Reset values (async): POS_X = LIMIT_X/2, POS_Y = LIMIT_Y/2, POS_Z = LIMIT_Z/2; BUTTONS = 0; CLICK_EVT = 0; UPD_VALID = 0; OVERRUN_CNT = 0. Both pipeline valid bits are cleared.
- Stage 1 (register on PKT_VALID) builds signed deltas, internal width POS_WIDTH+2:
  - dX = {sign, DX_RAW}, 9-bit. If the overflow bit is set, dX = +255 when sign = 0, -256 when sign = 1. dY is built the same way.
  - dZ = DZ_RAW sign-extended.
  - dX and dY are arithmetic-shifted right by SENS_SHIFT (floor toward -inf). dY is then negated if INVERT_Y = 1.
  - On a wrap-mode axis, the delta is clamped to ±(LIMIT-1).
- Stage 2 (commit, one cycle after stage 1), per axis: new = pos + d.
  - Saturate mode: new < 0 gives 0; new > LIMIT-1 gives LIMIT-1.
  - Wrap mode: new < 0 gives new + LIMIT; new >= LIMIT gives new - LIMIT.
- Commit also latches BUTTONS = STATUS_RAW[2:0] captured at stage 1. CLICK_EVT[i] = new[i] & ~old[i] for exactly that one cycle.
- Latency: positions, BUTTONS and CLICK_EVT change on the 2nd rising edge after the PKT_VALID cycle.
- Fully pipelined: PKT_VALID is accepted every cycle. Only stage 2 writes the position registers, so back-to-back packets accumulate correctly.
- Handshake:
  - A commit sets UPD_VALID.
  - UPD_ACK with UPD_VALID = 1 and no commit in that cycle clears UPD_VALID.
  - Commit with UPD_VALID = 1 and UPD_ACK = 0: UPD_VALID stays 1 and OVERRUN_CNT increments.
  - Commit in the same cycle as UPD_ACK: UPD_VALID stays 1, no increment.
  - UPD_ACK while UPD_VALID = 0 is ignored.
- RECENTRE:
  - Next edge: all positions = LIMIT/2, both pipeline stages flushed (in-flight packets discarded), UPD_VALID = 1 (counts as a commit for overrun).
  - BUTTONS is unchanged and no CLICK_EVT is generated.
  - RECENTRE has priority over a simultaneous stage-2 commit.
  - A PKT_VALID in the RECENTRE cycle is also discarded.
- Reset asserted mid-pipeline discards everything and returns all outputs to reset values immediately.

Test Plan:
- Reset, then PKT_VALID with status 0x08, dx 0x05, dy 0x03 -> 2 edges later POS_X = 85, POS_Y = 63, POS_Z = 128, UPD_VALID = 1; UPD_ACK -> UPD_VALID = 0 next cycle.
- status 0x18, dx 0x9C (-100) from X = 80 -> POS_X = 0 (saturate). status 0x48, dx 0x00 -> delta +255 -> POS_X = 159.
- POS_Z = 250, dz 0x0A, WRAP_Z = 1 -> POS_Z = 4. Then dz 0xF6 (-10) -> POS_Z = 250.
- Status 0x09 then 0x0B on consecutive cycles, no ACK -> CLICK_EVT = 001 then 010 on consecutive cycles, OVERRUN_CNT = 1. Repeat with UPD_ACK asserted on the 2nd commit -> no increment.
- SENS_SHIFT = 1: dx 0x07 -> +3. dx 0xF9 (-7, sign = 1) -> -4. INVERT_Y = 1, dy 0x05 -> POS_Y = 55 from 60.
- Packet issued, RECENTRE asserted the next cycle -> positions = 80/60/128, packet effect never appears, UPD_VALID = 1. RESET asserted mid-pipeline -> all outputs return to reset values immediately.
